// File: rtl/sequential_multiplicator_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier between several clients,
// with a watchdog that aborts and resets a multiplier that never reports done.
module sequential_multiplicator_arbiter #(
    parameter int WIDTH          = 8,
    parameter int REQUESTERS     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clock,
    input  logic                          reset_in,
    input  logic [REQUESTERS-1:0]         req_in,
    input  logic [REQUESTERS*WIDTH-1:0]   multiplicand_bus_in,
    input  logic [REQUESTERS*WIDTH-1:0]   multiplier_bus_in,
    output logic [REQUESTERS-1:0]         ack_out,
    output logic [REQUESTERS-1:0]         resp_valid_out,
    output logic [2*WIDTH-1:0]            product_out,
    output logic                          overflow_out,
    output logic                          error_out,
    output logic                          busy_out,
    output logic [WIDTH-1:0]              mult_multiplicand_out,
    output logic [WIDTH-1:0]              mult_multiplier_out,
    output logic                          mult_start_out,
    output logic                          mult_reset_out,
    input  logic                          mult_done_in,
    input  logic [2*WIDTH-1:0]            mult_product_in,
    input  logic                          mult_overflow_in
);
    localparam int PW = $clog2(REQUESTERS);
    localparam int CW = $clog2(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LAUNCH  = 2'd1;
    localparam logic [1:0] S_WAIT    = 2'd2;
    localparam logic [1:0] S_RESPOND = 2'd3;

    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRE  = CW'(TIMEOUT_CYCLES - 2);
    localparam logic [PW:0]   REQ_N    = (PW+1)'(REQUESTERS);
    localparam logic [PW-1:0] LAST_ID  = PW'(REQUESTERS - 1);

    logic [1:0]            r_state;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         r_grant;
    logic [WIDTH-1:0]      r_mcand;
    logic [WIDTH-1:0]      r_mplier;
    logic [CW-1:0]         r_cnt;
    logic [2*WIDTH-1:0]    r_product;
    logic                  r_overflow;
    logic                  r_error;
    logic                  r_wd_pulse;

    logic                  w_found;
    logic [PW-1:0]         w_sel;
    logic [PW:0]           w_sum;
    logic [WIDTH-1:0]      w_sel_mcand;
    logic [WIDTH-1:0]      w_sel_mplier;
    logic [REQUESTERS-1:0] w_grant_oh;
    logic [PW-1:0]         w_next_ptr;

    // First requesting client at or above the pointer, wrapping past the top index.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_sum   = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (w_sum >= REQ_N) begin
                w_sum = w_sum - REQ_N;
            end
            if (!w_found && req_in[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_sel   = w_sum[PW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_mcand  = '0;
        w_sel_mplier = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_sel == PW'(i)) begin
                w_sel_mcand  = multiplicand_bus_in[i*WIDTH +: WIDTH];
                w_sel_mplier = multiplier_bus_in[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_grant_oh = {{(REQUESTERS-1){1'b0}}, 1'b1} << r_grant;
    assign w_next_ptr = (r_grant == LAST_ID) ? '0 : r_grant + PW'(1);

    always_ff @(posedge clock) begin
        if (reset_in) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_grant    <= '0;
            r_mcand    <= '0;
            r_mplier   <= '0;
            r_cnt      <= '0;
            r_product  <= '0;
            r_overflow <= 1'b0;
            r_error    <= 1'b0;
            r_wd_pulse <= 1'b0;
        end else begin
            r_wd_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_sel;
                        r_mcand  <= w_sel_mcand;
                        r_mplier <= w_sel_mplier;
                        r_state  <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    r_cnt   <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mult_done_in) begin
                        r_product  <= mult_product_in;
                        r_overflow <= mult_overflow_in;
                        r_error    <= 1'b0;
                        r_state    <= S_RESPOND;
                    end else if (r_cnt == CNT_LAST) begin
                        r_product  <= '0;
                        r_overflow <= 1'b0;
                        r_error    <= 1'b1;
                        r_state    <= S_RESPOND;
                    end else begin
                        r_cnt      <= r_cnt + CW'(1);
                        // Reset pulse lands on the final WAIT cycle, just before the error response.
                        r_wd_pulse <= (r_cnt == CNT_PRE);
                    end
                end
                S_RESPOND: begin
                    r_ptr   <= w_next_ptr;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Strobes are masked during reset so an aborted operation never responds.
    assign ack_out               = (r_state == S_LAUNCH && !reset_in) ? w_grant_oh : '0;
    assign resp_valid_out        = (r_state == S_RESPOND && !reset_in) ? w_grant_oh : '0;
    assign mult_start_out        = (r_state == S_LAUNCH) && !reset_in;
    assign busy_out              = (r_state != S_IDLE) && !reset_in;
    assign mult_reset_out        = reset_in | r_wd_pulse;
    assign product_out           = r_product;
    assign overflow_out          = r_overflow;
    assign error_out             = r_error;
    assign mult_multiplicand_out = r_mcand;
    assign mult_multiplier_out   = r_mplier;

endmodule

// File: tb/tb_sequential_multiplicator_arbiter.sv
// Bench for sequential_multiplicator_arbiter: a latency-programmable multiplier
// stand-in plus a round-robin reference that tracks the expected pointer.
module tb_sequential_multiplicator_arbiter;
    localparam int W  = 8;
    localparam int RQ = 4;
    localparam int TO = 8;

    logic          clock = 1'b0;
    logic          reset_in;
    logic [RQ-1:0] req_in;
    logic [W-1:0]  mc [RQ];
    logic [W-1:0]  mp [RQ];
    logic [RQ*W-1:0] mcand_bus, mplier_bus;
    logic [RQ-1:0] ack_out, resp_valid_out;
    logic [2*W-1:0] product_out;
    logic          overflow_out, error_out, busy_out;
    logic [W-1:0]  mult_multiplicand_out, mult_multiplier_out;
    logic          mult_start_out, mult_reset_out;
    logic          mult_done_in = 1'b0;
    logic [2*W-1:0] mult_product_in;
    logic          mult_overflow_in;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int lat   = 1;
    bit hang  = 1'b0;
    int rem   = 0;
    int mptr  = 0;

    typedef struct {
        int          client;
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] exp_p;
        bit          exp_o;
    } vec_t;
    vec_t tbl [6];

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always_comb begin
        mcand_bus  = {mc[3], mc[2], mc[1], mc[0]};
        mplier_bus = {mp[3], mp[2], mp[1], mp[0]};
    end

    sequential_multiplicator_arbiter #(.WIDTH(W), .REQUESTERS(RQ), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset_in(reset_in), .req_in(req_in),
        .multiplicand_bus_in(mcand_bus), .multiplier_bus_in(mplier_bus),
        .ack_out(ack_out), .resp_valid_out(resp_valid_out), .product_out(product_out),
        .overflow_out(overflow_out), .error_out(error_out), .busy_out(busy_out),
        .mult_multiplicand_out(mult_multiplicand_out), .mult_multiplier_out(mult_multiplier_out),
        .mult_start_out(mult_start_out), .mult_reset_out(mult_reset_out),
        .mult_done_in(mult_done_in), .mult_product_in(mult_product_in),
        .mult_overflow_in(mult_overflow_in)
    );

    // Multiplier stand-in: done is high exactly lat cycles after the start cycle.
    assign mult_product_in  = 16'(mult_multiplicand_out) * 16'(mult_multiplier_out);
    assign mult_overflow_in = |mult_product_in[15:8];

    always @(posedge clock) begin
        if (mult_reset_out) begin
            rem <= 0;
            mult_done_in <= 1'b0;
        end else if (mult_start_out) begin
            mult_done_in <= (!hang && lat == 1);
            rem <= hang ? 0 : lat - 1;
        end else if (rem > 0) begin
            rem <= rem - 1;
            mult_done_in <= (rem == 1);
        end else begin
            mult_done_in <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int k);
        return 4'(1) << k;
    endfunction

    function automatic int pick(input logic [3:0] m, input int p);
        for (int k = 0; k < RQ; k++) begin
            if (m[(p + k) % RQ]) return (p + k) % RQ;
        end
        return -1;
    endfunction

    function automatic logic [15:0] refp(input int w);
        return 16'(int'(mc[w]) * int'(mp[w]));
    endfunction

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy_out !== 1'b0 && n < 60) begin
            @(negedge clock);
            n++;
        end
        chk({tag, " idle"}, 32'(busy_out), 32'd0);
    endtask

    task automatic xact(input logic [3:0] mask, input int w, input int l, input logic [15:0] ep,
                        input bit eo, input bit ee, input string tag, output int ack_cyc);
        int n;
        int rst_n;
        int rst_at;
        wait_idle(tag);
        lat = l;
        req_in = mask;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (ack_out == '0 && n < 20);
        ack_cyc = cyc;
        chk({tag, " ack delay"}, 32'(n), 32'd1);
        chk({tag, " ack"}, 32'(ack_out), 32'(oh(w)));
        chk({tag, " start"}, 32'(mult_start_out), 32'd1);
        req_in = mask & ~oh(w);
        n = 0;
        rst_n = 0;
        rst_at = -1;
        do begin
            @(negedge clock);
            n++;
            if (mult_reset_out) begin
                rst_n++;
                rst_at = n;
            end
        end while (resp_valid_out == '0 && n < 40);
        chk({tag, " resp"}, 32'(resp_valid_out), 32'(oh(w)));
        chk({tag, " resp delay"}, 32'(n), 32'(hang ? TO + 1 : l + 1));
        chk({tag, " product"}, 32'(product_out), 32'(ep));
        chk({tag, " overflow"}, 32'(overflow_out), 32'(eo));
        chk({tag, " error"}, 32'(error_out), 32'(ee));
        chk({tag, " mreset pulses"}, 32'(rst_n), 32'(hang ? 1 : 0));
        if (hang) chk({tag, " mreset timing"}, 32'(rst_at), 32'(n - 1));
        mptr = (w + 1) % RQ;
    endtask

    initial begin
        int ac;
        int prev;
        int bad;
        int w;
        int l;
        logic [3:0] m;

        tbl[0] = '{2, 8'd13,  8'd11,  1, 16'd143,   1'b0};
        tbl[1] = '{0, 8'd255, 8'd255, 3, 16'd65025, 1'b1};
        tbl[2] = '{1, 8'd0,   8'd200, 2, 16'd0,     1'b0};
        tbl[3] = '{3, 8'd200, 8'd0,   4, 16'd0,     1'b0};
        tbl[4] = '{3, 8'd16,  8'd16,  5, 16'd256,   1'b1};
        tbl[5] = '{1, 8'd1,   8'd255, 1, 16'd255,   1'b0};

        for (int i = 0; i < RQ; i++) begin
            mc[i] = 8'(i + 3);
            mp[i] = 8'(i + 10);
        end
        reset_in = 1'b1;
        req_in = '0;
        repeat (3) @(negedge clock);
        chk("rst mreset", 32'(mult_reset_out), 32'd1);
        chk("rst ack", 32'(ack_out), 32'd0);
        chk("rst resp", 32'(resp_valid_out), 32'd0);
        chk("rst busy", 32'(busy_out), 32'd0);
        chk("rst product", 32'(product_out), 32'd0);
        chk("rst start", 32'(mult_start_out), 32'd0);
        chk("rst operands", {16'd0, mult_multiplicand_out, mult_multiplier_out}, 32'd0);
        reset_in = 1'b0;
        #1;
        chk("rst release mreset", 32'(mult_reset_out), 32'd0);
        @(negedge clock);

        // Fairness: everyone requesting; grants rotate and are L+3 apart.
        prev = 0;
        for (int k = 0; k < 5; k++) begin
            w = k % RQ;
            xact(4'hF, w, 2, refp(w), refp(w) > 16'd255, 1'b0, $sformatf("fair%0d", k), ac);
            if (k > 0) chk($sformatf("fair%0d spacing", k), 32'(ac - prev), 32'd5);
            prev = ac;
        end
        req_in = '0;

        for (int k = 0; k < 6; k++) begin
            mc[tbl[k].client] = tbl[k].a;
            mp[tbl[k].client] = tbl[k].b;
            xact(oh(tbl[k].client), tbl[k].client, tbl[k].lat, tbl[k].exp_p, tbl[k].exp_o,
                 1'b0, $sformatf("vec%0d", k), ac);
        end

        // Wrap-around from pointer 3 with only clients 3 and 1 requesting.
        xact(oh(2), 2, 2, refp(2), refp(2) > 16'd255, 1'b0, "wrap pre", ac);
        xact(4'b1010, 3, 1, refp(3), refp(3) > 16'd255, 1'b0, "wrap 3", ac);
        xact(4'b0010, 1, 2, refp(1), refp(1) > 16'd255, 1'b0, "wrap 1", ac);
        xact(4'b1111, 2, 1, refp(2), refp(2) > 16'd255, 1'b0, "wrap ptr", ac);

        // Hung multiplier, then recovery with the pointer advanced past the aborted client.
        mc[1] = 8'd50; mp[1] = 8'd60;
        hang = 1'b1;
        xact(oh(1), 1, 3, 16'd0, 1'b0, 1'b1, "hang", ac);
        hang = 1'b0;
        mc[0] = 8'd5; mp[0] = 8'd6;
        xact(4'b0011, 0, 2, 16'd30, 1'b0, 1'b0, "after hang", ac);

        // Reset pulse while waiting on the multiplier.
        wait_idle("midrst");
        lat = 5;
        mc[2] = 8'd7; mp[2] = 8'd9;
        req_in = oh(2);
        bad = 0;
        do begin
            @(negedge clock);
            bad++;
        end while (ack_out == '0 && bad < 20);
        chk("midrst ack", 32'(ack_out), 32'(oh(2)));
        req_in = '0;
        repeat (2) @(negedge clock);
        reset_in = 1'b1;
        #1;
        chk("midrst mreset", 32'(mult_reset_out), 32'd1);
        chk("midrst resp during", 32'(resp_valid_out), 32'd0);
        @(negedge clock);
        chk("midrst product", 32'(product_out), 32'd0);
        chk("midrst flags", {29'd0, overflow_out, error_out, busy_out}, 32'd0);
        chk("midrst strobes", {23'd0, ack_out, mult_start_out, resp_valid_out}, 32'd0);
        chk("midrst operands", {16'd0, mult_multiplicand_out, mult_multiplier_out}, 32'd0);
        reset_in = 1'b0;
        #1;
        chk("midrst mreset release", 32'(mult_reset_out), 32'd0);
        bad = 0;
        repeat (12) begin
            @(negedge clock);
            if (resp_valid_out != '0) bad++;
        end
        chk("midrst no resp", 32'(bad), 32'd0);
        mptr = 0;
        xact(4'hF, 0, 2, refp(0), refp(0) > 16'd255, 1'b0, "midrst regrant", ac);

        // Random traffic against the round-robin reference.
        for (int k = 0; k < 40; k++) begin
            for (int i = 0; i < RQ; i++) begin
                mc[i] = 8'($urandom_range(0, 255));
                mp[i] = 8'($urandom_range(0, 255));
            end
            m = 4'($urandom_range(1, 15));
            l = int'($urandom_range(1, 5));
            w = pick(m, mptr);
            xact(m, w, l, refp(w), refp(w) > 16'd255, 1'b0, $sformatf("rnd%0d", k), ac);
        end
        req_in = '0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
